// File: rtl/branch_exec_pipe.sv
// Two-stage, multi-lane branch executor. E1 captures a bundle of operands
// after forwarding selection. E2 holds the evaluated taken/link results and
// a single prioritised fetch redirect. While a redirect is outstanding,
// newly arriving wrong-path bundles are dropped and counted.
module branch_exec_pipe #(
   parameter  int XLEN  = 32,
   parameter  int LANES = 2,
   parameter  int IMM_W = 22,
   parameter  int CNT_W = 16,
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*XLEN-1:0]   in_pc,
   input  logic [LANES-1:0]        in_is_nop,
   input  logic [LANES-1:0]        in_is_jmp,
   input  logic [LANES-1:0]        in_is_imm_type,
   input  logic [LANES-1:0]        in_zero_ext,
   input  logic [2*LANES-1:0]      in_op,
   input  logic [LANES*XLEN-1:0]   in_rs1_data,
   input  logic [LANES*XLEN-1:0]   in_rs2_data,
   input  logic [LANES*XLEN-1:0]   in_rs1_fwd_data,
   input  logic [LANES*XLEN-1:0]   in_rs2_fwd_data,
   input  logic [LANES-1:0]        in_rs1_fwd,
   input  logic [LANES-1:0]        in_rs2_fwd,
   input  logic [LANES*IMM_W-1:0]  in_imm,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES-1:0]        out_taken,
   output logic [LANES*XLEN-1:0]   out_ret_addr,
   output logic [LANES-1:0]        out_rd_wr_en,
   output logic                    redirect_valid,
   output logic [XLEN-1:0]         redirect_pc,
   output logic [LW-1:0]           redirect_lane,
   output logic [CNT_W-1:0]        squash_count
);

   typedef enum logic {RUN, SHADOW} state_t;

   state_t state, state_nxt;

   // Per-lane views of the flat input buses.
   logic [LANES-1:0][XLEN-1:0]  pc_v, rs1_v, rs2_v, rs1f_v, rs2f_v;
   logic [LANES-1:0][XLEN-1:0]  opa_sel, opb_sel;
   logic [LANES-1:0][IMM_W-1:0] imm_v;
   logic [LANES-1:0][1:0]       op_v;

   assign pc_v   = in_pc;
   assign rs1_v  = in_rs1_data;
   assign rs2_v  = in_rs2_data;
   assign rs1f_v = in_rs1_fwd_data;
   assign rs2f_v = in_rs2_fwd_data;
   assign imm_v  = in_imm;
   assign op_v   = in_op;

   // E1 stage storage.
   logic                        e1_valid;
   logic [LANES-1:0][XLEN-1:0]  e1_pc, e1_a, e1_b;
   logic [LANES-1:0][IMM_W-1:0] e1_imm;
   logic [LANES-1:0][1:0]       e1_op;
   logic [LANES-1:0]            e1_nop, e1_jmp, e1_immt, e1_zext;

   // E2 stage state not directly visible as a port.
   logic e2_valid, e2_redir;

   // Combinational evaluation of the bundle sitting in E1.
   logic [LANES-1:0]            c_taken, c_wr;
   logic [LANES-1:0][XLEN-1:0]  c_ret, c_tgt;
   logic                        c_any;
   logic [XLEN-1:0]             c_rpc;
   logic [LW-1:0]               c_rlane;

   // Handshake and squash control.
   logic e2_adv, e1_move, acc, move_taken, discard, complete;

   assign e2_adv     = !e2_valid || out_ready;
   assign in_ready   = !e1_valid || e2_adv;
   assign acc        = in_valid && in_ready;
   assign e1_move    = e1_valid && e2_adv;
   assign move_taken = e1_move && c_any;
   assign complete   = e2_valid && out_ready;
   // A bundle is wrong-path if it arrives while a redirect is leaving E1 or
   // still waiting in E2 (which includes the edge on which it completes).
   assign discard    = (state == SHADOW) || move_taken;

   assign out_valid      = e2_valid;
   assign redirect_valid = e2_valid && e2_redir;

   // Forwarding mux in front of E1.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      opa_sel = '0;
      opb_sel = '0;
      for (int i = 0; i < LANES; i++) begin
         opa_sel[i] = in_rs1_fwd[i] ? rs1f_v[i] : rs1_v[i];
         opb_sel[i] = in_rs2_fwd[i] ? rs2f_v[i] : rs2_v[i];
      end
   end

   // Per-lane evaluation and lowest-index redirect selection from E1.
   always_comb begin : eval
      logic [XLEN-1:0] imm_x;
      logic            lt;
      logic            cond;
      c_taken = '0;
      c_wr    = '0;
      c_ret   = '0;
      c_tgt   = '0;
      c_rpc   = '0;
      c_rlane = '0;
      imm_x   = '0;
      lt      = 1'b0;
      cond    = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         // JAL uses the full raw immediate; everything else uses imm[11:0].
         if (e1_jmp[i] && !e1_immt[i])
            imm_x = XLEN'($signed(e1_imm[i]));
         else
            imm_x = XLEN'($signed(e1_imm[i][11:0]));
         lt = e1_zext[i] ? (e1_a[i] < e1_b[i])
                         : ($signed(e1_a[i]) < $signed(e1_b[i]));
         case (e1_op[i])
            2'b00:   cond = (e1_a[i] == e1_b[i]);
            2'b01:   cond = (e1_a[i] != e1_b[i]);
            2'b10:   cond = lt;
            default: cond = !lt;
         endcase
         // JALR targets are register-relative with bit 0 cleared.
         if (e1_jmp[i] && e1_immt[i])
            c_tgt[i] = (e1_a[i] + imm_x) & {{(XLEN-1){1'b1}}, 1'b0};
         else
            c_tgt[i] = e1_pc[i] + imm_x;
         c_taken[i] = !e1_nop[i] && (e1_jmp[i] || cond);
         c_wr[i]    = !e1_nop[i] && e1_jmp[i];
         c_ret[i]   = e1_pc[i] + XLEN'(4);
      end
      // Scan high to low so the lowest taken lane is the one that sticks.
      for (int i = LANES - 1; i >= 0; i--) begin
         if (c_taken[i]) begin
            c_rpc   = c_tgt[i];
            c_rlane = LW'(i);
         end
      end
   end

   assign c_any = |c_taken;

   // RUN/SHADOW next-state logic; flush always returns to RUN.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (move_taken) state_nxt = SHADOW;
         SHADOW:  if (complete)   state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
      if (flush) state_nxt = RUN;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples values from before the edge.
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   // E1 payload capture; qualified by e1_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      // NOTE: pure datapath registers are left unreset; the valid bit
      // alone decides whether their contents mean anything.
      if (acc && !discard && !flush) begin
         e1_pc   <= pc_v;
         e1_a    <= opa_sel;
         e1_b    <= opb_sel;
         e1_imm  <= imm_v;
         e1_op   <= op_v;
         e1_nop  <= in_is_nop;
         e1_jmp  <= in_is_jmp;
         e1_immt <= in_is_imm_type;
         e1_zext <= in_zero_ext;
      end
   end

   // Valid bits, E2 results and the saturating squash counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e1_valid      <= 1'b0;
         e2_valid      <= 1'b0;
         e2_redir      <= 1'b0;
         out_taken     <= '0;
         out_ret_addr  <= '0;
         out_rd_wr_en  <= '0;
         redirect_pc   <= '0;
         redirect_lane <= '0;
         squash_count  <= '0;
      end else if (flush) begin
         e1_valid <= 1'b0;
         e2_valid <= 1'b0;
      end else begin
         if (acc && !discard) e1_valid <= 1'b1;
         else if (e1_move)    e1_valid <= 1'b0;
         if (e2_adv) begin
            e2_valid <= e1_valid;
            if (e1_valid) begin
               out_taken     <= c_taken;
               out_ret_addr  <= c_ret;
               out_rd_wr_en  <= c_wr;
               e2_redir      <= c_any;
               redirect_pc   <= c_rpc;
               redirect_lane <= c_rlane;
            end
         end
         if (acc && discard && (squash_count != '1))
            squash_count <= squash_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_exec_pipe.sv
// Self-checking bench for branch_exec_pipe: directed scenarios with literal
// expectations plus a randomized run against a transaction-level model.
module tb_branch_exec_pipe;

   localparam int XLEN  = 32;
   localparam int LANES = 2;
   localparam int IMM_W = 22;
   localparam int CNT_W = 16;
   localparam int LW    = 1;

   logic                   clk, rst_n, flush, in_valid, in_ready;
   logic [LANES*XLEN-1:0]  in_pc, in_rs1_data, in_rs2_data, in_rs1_fwd_data, in_rs2_fwd_data;
   logic [LANES-1:0]       in_is_nop, in_is_jmp, in_is_imm_type, in_zero_ext, in_rs1_fwd, in_rs2_fwd;
   logic [2*LANES-1:0]     in_op;
   logic [LANES*IMM_W-1:0] in_imm;
   logic                   out_valid, out_ready, redirect_valid;
   logic [LANES-1:0]       out_taken, out_rd_wr_en;
   logic [LANES*XLEN-1:0]  out_ret_addr;
   logic [XLEN-1:0]        redirect_pc;
   logic [LW-1:0]          redirect_lane;
   logic [CNT_W-1:0]       squash_count;

   branch_exec_pipe #(.XLEN(XLEN), .LANES(LANES), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_is_nop(in_is_nop), .in_is_jmp(in_is_jmp),
      .in_is_imm_type(in_is_imm_type), .in_zero_ext(in_zero_ext), .in_op(in_op),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_rs1_fwd_data(in_rs1_fwd_data), .in_rs2_fwd_data(in_rs2_fwd_data),
      .in_rs1_fwd(in_rs1_fwd), .in_rs2_fwd(in_rs2_fwd), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_taken(out_taken), .out_ret_addr(out_ret_addr), .out_rd_wr_en(out_rd_wr_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_lane(redirect_lane), .squash_count(squash_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [LANES*XLEN-1:0]  pc, rs1, rs2, rs1f, rs2f;
      logic [LANES-1:0]       nop, jmp, immt, zext, f1, f2;
      logic [2*LANES-1:0]     op;
      logic [LANES*IMM_W-1:0] imm;
   } bundle_t;

   typedef struct {
      logic [LANES-1:0]      taken, wr;
      logic [LANES*XLEN-1:0] ret;
      logic                  rv;
      logic [XLEN-1:0]       rpc;
      int                    rlane;
   } res_t;

   typedef struct {
      res_t r;
      int   age;
   } ent_t;

   int n_cmp = 0;
   int n_fail = 0;

   // Stimulus state and model state.
   bundle_t          cur;
   logic             s_valid, s_flush, s_ready;
   ent_t             q[$];
   logic [CNT_W-1:0] m_sq;
   bit               m_acc;
   bit               saw_not_ready;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected results of one bundle, straight from the ISA rules.
   function automatic res_t compute(input bundle_t b);
      res_t             r;
      logic [XLEN-1:0]  pc, a, bv, tgt;
      logic [IMM_W-1:0] raw;
      longint           immv, s_a, s_b, t;
      bit               lt, cond;
      r.taken = '0; r.wr = '0; r.ret = '0; r.rv = 1'b0; r.rpc = '0; r.rlane = 0;
      for (int i = 0; i < LANES; i++) begin
         pc  = b.pc[i*XLEN +: XLEN];
         a   = b.f1[i] ? b.rs1f[i*XLEN +: XLEN] : b.rs1[i*XLEN +: XLEN];
         bv  = b.f2[i] ? b.rs2f[i*XLEN +: XLEN] : b.rs2[i*XLEN +: XLEN];
         raw = b.imm[i*IMM_W +: IMM_W];
         if (b.jmp[i] && !b.immt[i]) begin
            immv = longint'(raw);
            if (raw[IMM_W-1]) immv = immv - (longint'(1) << IMM_W);
         end else begin
            immv = longint'(raw[11:0]);
            if (raw[11]) immv = immv - 4096;
         end
         s_a = longint'(a);
         if (a[XLEN-1]) s_a = s_a - (longint'(1) << XLEN);
         s_b = longint'(bv);
         if (bv[XLEN-1]) s_b = s_b - (longint'(1) << XLEN);
         lt = b.zext[i] ? (longint'(a) < longint'(bv)) : (s_a < s_b);
         case (b.op[2*i +: 2])
            2'd0:    cond = (a == bv);
            2'd1:    cond = (a != bv);
            2'd2:    cond = lt;
            default: cond = !lt;
         endcase
         if (b.jmp[i] && b.immt[i]) begin
            t = longint'(a) + immv;
            tgt = t[XLEN-1:0];
            tgt[0] = 1'b0;
         end else begin
            t = longint'(pc) + immv;
            tgt = t[XLEN-1:0];
         end
         r.taken[i] = !b.nop[i] && (b.jmp[i] || cond);
         r.wr[i]    = !b.nop[i] && b.jmp[i];
         t = longint'(pc) + 4;
         r.ret[i*XLEN +: XLEN] = t[XLEN-1:0];
         if (r.taken[i] && !r.rv) begin
            r.rv = 1'b1;
            r.rpc = tgt;
            r.rlane = i;
         end
      end
      return r;
   endfunction

   // Transaction view: at most two bundles in flight; one is visible once it
   // has survived one more edge after acceptance; a new bundle is dropped if
   // any older in-flight bundle redirects.
   task automatic model_edge();
      int n;
      bit ready, complete, discard;
      ent_t e;
      n = q.size();
      ready = !(n >= 2 && !s_ready);
      m_acc = 1'b0;
      if (s_flush) begin
         q.delete();
      end else begin
         complete = (n > 0) && (q[0].age >= 1) && s_ready;
         discard = 1'b0;
         if (s_valid && ready) begin
            foreach (q[k]) if (q[k].r.rv) discard = 1'b1;
            if (discard && (m_sq != {CNT_W{1'b1}})) m_sq = m_sq + 1'b1;
         end
         if (complete) void'(q.pop_front());
         foreach (q[k]) q[k].age = q[k].age + 1;
         if (s_valid && ready && !discard) begin
            e.r = compute(cur);
            e.age = 0;
            q.push_back(e);
            m_acc = 1'b1;
         end
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_sq = '0;
   endtask

   task automatic compare();
      bit   exp_valid;
      res_t r;
      exp_valid = (q.size() > 0) && (q[0].age >= 1);
      check("out_valid", out_valid, exp_valid);
      check("in_ready", in_ready, !(q.size() >= 2 && !s_ready));
      check("squash_count", squash_count, m_sq);
      if (!in_ready) saw_not_ready = 1'b1;
      if (exp_valid) begin
         r = q[0].r;
         check("out_taken", out_taken, r.taken);
         check("out_ret_addr", out_ret_addr, r.ret);
         check("out_rd_wr_en", out_rd_wr_en, r.wr);
         check("redirect_valid", redirect_valid, r.rv);
         check("redirect_pc", redirect_pc, r.rpc);
         check("redirect_lane", redirect_lane, r.rlane);
      end
   endtask

   task automatic drive();
      in_valid = s_valid; flush = s_flush; out_ready = s_ready;
      in_pc = cur.pc; in_rs1_data = cur.rs1; in_rs2_data = cur.rs2;
      in_rs1_fwd_data = cur.rs1f; in_rs2_fwd_data = cur.rs2f;
      in_is_nop = cur.nop; in_is_jmp = cur.jmp; in_is_imm_type = cur.immt;
      in_zero_ext = cur.zext; in_rs1_fwd = cur.f1; in_rs2_fwd = cur.f2;
      in_op = cur.op; in_imm = cur.imm;
   endtask

   // Called at a falling edge: drive, check, advance the model, next fall.
   task automatic tick();
      drive();
      #1;
      compare();
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      s_flush = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic bundle_t nop_bundle(input logic [XLEN-1:0] pc0);
      bundle_t b;
      b.rs1 = '0; b.rs2 = '0; b.rs1f = '0; b.rs2f = '0;
      b.nop = '1; b.jmp = '0; b.immt = '0; b.zext = '0; b.f1 = '0; b.f2 = '0;
      b.op = '0; b.imm = '0;
      for (int i = 0; i < LANES; i++) b.pc[i*XLEN +: XLEN] = pc0 + XLEN'(4 * i);
      return b;
   endfunction

   function automatic logic [XLEN-1:0] pick_val();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic bundle_t rand_bundle();
      bundle_t b;
      logic [XLEN-1:0] v;
      for (int i = 0; i < LANES; i++) begin
         v = $urandom;
         b.pc[i*XLEN +: XLEN]   = v & ~32'h3;
         v = pick_val();
         b.rs1[i*XLEN +: XLEN]  = v;
         b.rs2[i*XLEN +: XLEN]  = ($urandom_range(0, 2) == 0) ? v : pick_val();
         b.rs1f[i*XLEN +: XLEN] = pick_val();
         b.rs2f[i*XLEN +: XLEN] = pick_val();
         b.imm[i*IMM_W +: IMM_W] = IMM_W'($urandom);
         b.nop[i]  = ($urandom_range(0, 4) == 0);
         b.jmp[i]  = ($urandom_range(0, 3) == 0);
         b.immt[i] = $urandom_range(0, 1) != 0;
         b.zext[i] = $urandom_range(0, 1) != 0;
         b.f1[i]   = $urandom_range(0, 1) != 0;
         b.f2[i]   = $urandom_range(0, 1) != 0;
         b.op[2*i +: 2] = 2'($urandom_range(0, 3));
      end
      return b;
   endfunction

   initial begin
      int k;
      rst_n = 1'b0;
      s_valid = 1'b0; s_flush = 1'b0; s_ready = 1'b1;
      saw_not_ready = 1'b0;
      cur = nop_bundle('0);
      drive();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_squash", squash_count, 0);
      check("rst_redirect_valid", redirect_valid, 0);
      check("rst_redirect_pc", redirect_pc, 0);
      check("rst_out_taken", out_taken, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // BEQ taken in lane 0, followed by a wrong-path bundle.
      cur = nop_bundle(32'h100);
      cur.nop[0] = 1'b0; cur.op[1:0] = 2'b00;
      cur.rs1[31:0] = 32'd5; cur.rs2[31:0] = 32'd5; cur.imm[IMM_W-1:0] = 22'h010;
      s_valid = 1'b1; s_ready = 1'b1;
      tick();
      cur = nop_bundle(32'h300);
      tick();
      s_valid = 1'b0;
      check("beq_out_valid", out_valid, 1);
      check("beq_out_taken", out_taken, 2'b01);
      check("beq_redirect_pc", redirect_pc, 32'h110);
      check("beq_redirect_lane", redirect_lane, 0);
      check("beq_squash", squash_count, 1);
      idle(3);

      // Unsigned BLTU not taken in lane 0, signed BLT taken in lane 1.
      cur = nop_bundle(32'h200);
      cur.nop = 2'b00; cur.op = 4'b1010; cur.zext = 2'b01;
      cur.rs1 = {32'hFFFF_FFFF, 32'hFFFF_FFFF}; cur.rs2 = {32'd1, 32'd1};
      cur.imm[IMM_W +: IMM_W] = 22'h000FFC;
      s_valid = 1'b1;
      tick();
      idle(1);
      check("blt_out_taken", out_taken, 2'b10);
      check("blt_redirect_pc", redirect_pc, 32'h200);
      check("blt_redirect_lane", redirect_lane, 1);
      idle(2);

      // JALR through forwarded rs1; lane 1 return address wraps.
      cur = nop_bundle(32'h40);
      cur.pc[XLEN +: XLEN] = 32'hFFFF_FFFC;
      cur.nop[0] = 1'b0; cur.jmp[0] = 1'b1; cur.immt[0] = 1'b1;
      cur.f1[0] = 1'b1; cur.rs1f[31:0] = 32'h1001; cur.imm[IMM_W-1:0] = 22'h002;
      s_valid = 1'b1;
      tick();
      idle(1);
      check("jalr_redirect_pc", redirect_pc, 32'h1002);
      check("jalr_ret_addr", out_ret_addr, {32'h0, 32'h44});
      check("jalr_rd_wr_en", out_rd_wr_en, 2'b01);
      check("jalr_redirect_valid", redirect_valid, 1);
      idle(2);

      // Backpressure: four non-taken bundles with the sink stalled 5 cycles.
      saw_not_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 30 && !(k == 4 && q.size() == 0); c++) begin
         s_ready = (c >= 5);
         s_valid = (k < 4);
         cur = nop_bundle(32'h1000 + 32'(k * 16));
         tick();
         if (m_acc) k++;
         if (c == 4) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ret", out_ret_addr[31:0], 32'h1004);
         end
      end
      check("bp_all_accepted", k, 4);
      check("bp_in_ready_dropped", saw_not_ready, 1);
      idle(2);

      // Flush while the redirect bundle is stalled in E2 during SHADOW.
      s_ready = 1'b0;
      cur = nop_bundle(32'h500);
      cur.nop[0] = 1'b0; cur.jmp[0] = 1'b1; cur.imm[IMM_W-1:0] = 22'h100;
      s_valid = 1'b1;
      tick();
      idle(1);
      cur = nop_bundle(32'h600);
      s_valid = 1'b1;
      tick();
      check("shadow_squash", squash_count, 2);
      check("shadow_stalled_valid", out_valid, 1);
      cur = nop_bundle(32'h700);
      s_flush = 1'b1;
      tick();
      s_flush = 1'b0; s_valid = 1'b0;
      check("flush_out_valid", out_valid, 0);
      check("flush_squash", squash_count, 2);
      s_ready = 1'b1;
      cur = nop_bundle(32'h800);
      s_valid = 1'b1;
      tick();
      idle(1);
      check("post_flush_valid", out_valid, 1);
      check("post_flush_ret", out_ret_addr[31:0], 32'h804);
      idle(2);

      // Asynchronous reset with both stages full.
      s_ready = 1'b0;
      cur = nop_bundle(32'h900);
      s_valid = 1'b1;
      tick();
      tick();
      s_valid = 1'b0;
      drive();
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_in_ready", in_ready, 1);
      check("async_rst_squash", squash_count, 0);
      check("async_rst_taken", out_taken, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      s_ready = 1'b1;
      idle(3);

      // Randomized traffic with random backpressure and occasional flush.
      for (int c = 0; c < 3000; c++) begin
         s_valid = ($urandom_range(0, 9) < 7);
         s_ready = ($urandom_range(0, 9) < 7);
         s_flush = ($urandom_range(0, 49) == 0);
         cur = rand_bundle();
         tick();
      end
      s_ready = 1'b1;
      idle(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_exec_pipe.md
# branch_exec_pipe

Pipelined, multi-lane successor to the single-slot branch executor. It accepts one VLIW bundle of `LANES` branch/jump slots per cycle and registers operands after forwarding selection. It evaluates every lane and returns per-lane taken/link results plus one prioritised fetch redirect, two cycles after acceptance. It sits between the issue stage and fetch/writeback, with valid/ready handshakes on both sides, and automatically squashes wrong-path bundles while a redirect is outstanding.

## Interface
- `XLEN`, 32, data/PC width
- `LANES`, 2, branch slots per bundle (≥1)
- `IMM_W`, 22, raw immediate width per lane (≥12)
- `CNT_W`, 16, squash counter width
- `clk`  in  1  clock; everything rising-edge
- `rst_n`  in  1  reset; asynchronous and active-low
- `flush`  in  1  synchronous pipeline kill
- `in_valid` in 1 / `in_ready` out 1  bundle handshake
- `in_pc`  in  LANES*XLEN  per-lane PC, lane i at [i*XLEN +: XLEN]
- `in_is_nop`, `in_is_jmp`, `in_is_imm_type`, `in_zero_ext`  in  LANES each  per-lane decode flags
- `in_op`  in  2*LANES  00 BEQ, 01 BNE, 10 BLT(U), 11 BGE(U)
- `in_rs1_data`, `in_rs2_data`, `in_rs1_fwd_data`, `in_rs2_fwd_data`  in  LANES*XLEN each
- `in_rs1_fwd`, `in_rs2_fwd`  in  LANES each  select forwarded operand
- `in_imm`  in  LANES*IMM_W  raw immediate
- `out_valid` out 1 / `out_ready` in 1  result handshake
- `out_taken`  out  LANES  per-lane taken
- `out_ret_addr`  out  LANES*XLEN  per-lane pc+4
- `out_rd_wr_en`  out  LANES  per-lane link write enable
- `redirect_valid`  out  1  some lane taken in output bundle
- `redirect_pc`  out  XLEN  target of winning lane
- `redirect_lane`  out  max(1,$clog2(LANES))  index of winning lane
- `squash_count`  out  CNT_W  bundles dropped in shadow, saturating

## Operation
- Forwarding mux applied at input: opX = fwd ? fwd_data : data; selected values captured into E1.
- Stage E1 holds the accepted bundle. The E1→E2 transfer computes results combinationally from E1; E2 registers them and drives all `out_*` and `redirect_*`.
- Immediates: JAL (`is_jmp`=1, `is_imm_type`=0) sign-extends the full IMM_W. All others sign-extend `imm[11:0]`.
- Targets: branch and JAL = pc + imm. JALR = (opA + imm) with bit 0 cleared. All sums are modulo 2^XLEN.
- Branch compare: BEQ/BNE use equality. Op 10/11 use unsigned `<`/`>=` when `zero_ext`=1, signed otherwise.
- Jumps are always taken, and `out_rd_wr_en`=1 for JAL and JALR. Branches never write.
- Nop lanes: taken=0, rd_wr_en=0, and `ret_addr` = pc+4 regardless.
- Redirect: the lowest-index taken lane wins. `redirect_valid` = OR of taken. `redirect_pc`/`redirect_lane` are 0 when nothing is taken.
- FSM RUN/SHADOW:
  - RUN→SHADOW on the edge where a bundle with any taken lane moves E1→E2.
  - SHADOW→RUN on the edge where that bundle completes out_valid&&out_ready.
  - Any bundle accepted on the RUN→SHADOW edge, during SHADOW, or on the SHADOW→RUN edge is discarded: not written into E1, and `squash_count` increments by 1, saturating at all-ones.
- `flush` (rst_n high):
  - Clears the E1/E2 valids and forces RUN.
  - An input accepted that cycle is discarded without counting.
  - `squash_count` is unchanged.

## Timing
- Reset values: `out_valid`, `out_taken`, `out_ret_addr`, `out_rd_wr_en`, `redirect_valid`, `redirect_pc`, `redirect_lane`, `squash_count` all 0. FSM=RUN. E1/E2 empty, so `in_ready`=1.
- Latency: bundle accepted at edge T → `out_valid` high after edge T+1 (2 cycles). Throughput is 1 bundle/cycle.
- `in_ready` = !E1_valid || (!E2_valid || out_ready), combinational, with no dependence on `in_valid`.
- E2 advances when !E2_valid || out_ready. While out_valid && !out_ready, all outputs hold stable.
- In SHADOW, E1 stays empty, so `in_ready`=1 and wrong-path bundles drain at 1 per cycle.
- Async reset mid-operation: all state returns to its reset value immediately. In-flight bundles are lost.
- Flush and a completing redirect on the same edge: flush wins, and the FSM ends in RUN.

## Test plan
- Reset: assert rst_n=0 with E1/E2 full → all outputs 0, `in_ready`=1, `squash_count`=0, no output on release.
- BEQ lane0, pc=0x100, rs1=rs2=5, imm=0x010, followed by one more valid bundle → 2 cycles later `out_taken`=01, `redirect_pc`=0x110, `redirect_lane`=0. The second bundle is never output, and `squash_count`=1.
- Lane0 BLTU rs1=0xFFFFFFFF rs2=1 (not taken); lane1 BLT same operands, pc=0x204, imm=0xFFC → `out_taken`=10, `redirect_pc`=0x200, `redirect_lane`=1.
- JALR lane0, rs1_data=0, rs1_fwd=1, fwd_data=0x1001, imm=0x002, pc=0x40 → `redirect_pc`=0x1002, `out_ret_addr`=0x44, `out_rd_wr_en`=01. Also pc=0xFFFFFFFC → ret 0x0.
- Backpressure: stream 4 non-taken bundles with out_ready=0 for 5 cycles → `in_ready` drops once E1 and E2 are full. Outputs are held stable, and all 4 bundles emerge in order with none lost.
- Flush in SHADOW with the redirect bundle stalled in E2 → `out_valid`=0 next cycle, FSM=RUN, `squash_count` unchanged. The next bundle is output normally after 2 cycles.
